// File: rtl/pc_sequencer.sv
// Program counter / control-flow stage with a return-address stack for BR.SUB/RETURN.
// Optional macro PC_STACK_WRAP_EN: a BR.SUB on a full stack overwrites the oldest entry and still branches.
module pc_sequencer #(
  parameter int PC_WIDTH     = 8,
  parameter int STACK_DEPTH  = 4,
  parameter int RESET_VECTOR = 0
) (
  input  logic                           clock,
  input  logic                           resetN,
  input  logic [3:0]                     ALUOP,
  input  logic                           zero,
  input  logic                           negative,
  input  logic [1:0]                     branchCond,
  input  logic [PC_WIDTH-1:0]            branchTarget,
  input  logic                           stall,
  output logic [PC_WIDTH-1:0]            pc,
  output logic                           branchTaken,
  output logic [$clog2(STACK_DEPTH):0]   stackDepth,
  output logic                           stackOverflow,
  output logic                           stackUnderflow
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [PC_WIDTH-1:0] RST_PC = RESET_VECTOR[PC_WIDTH-1:0];
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  localparam logic [3:0] OP_BR     = 4'b1001;
  localparam logic [3:0] OP_BRC    = 4'b1010;
  localparam logic [3:0] OP_BRSUB  = 4'b1011;
  localparam logic [3:0] OP_RETURN = 4'b1100;

  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic                taken_q, taken_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic [AW-1:0]       sp_q, sp_d, sp_prev;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                push_en, cond_true;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  // sp_q points at the next free slot; the buffer is circular so that, when full,
  // sp_q also addresses the oldest entry.
  assign pc_inc  = pc_q + PC_WIDTH'(1);
  assign sp_prev = sp_q - AW'(1);

  always_comb begin
    cond_true = 1'b0;
    case (branchCond)
      2'b00: cond_true = zero;
      2'b01: cond_true = negative;
      2'b10: cond_true = !zero;
      2'b11: cond_true = !negative;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    pc_d    = pc_inc;
    taken_d = 1'b0;
    depth_d = depth_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (stall) begin
      pc_d = pc_q;
    end else begin
      case (ALUOP)
        OP_BR: begin
          pc_d    = branchTarget;
          taken_d = 1'b1;
        end
        OP_BRC: begin
          if (cond_true) begin
            pc_d    = branchTarget;
            taken_d = 1'b1;
          end
        end
        OP_BRSUB: begin
          if (depth_q != FULL) begin
            push_en = 1'b1;
            sp_d    = sp_q + AW'(1);
            depth_d = depth_q + DW'(1);
            pc_d    = branchTarget;
            taken_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
`ifdef PC_STACK_WRAP_EN
            push_en = 1'b1;
            sp_d    = sp_q + AW'(1);
            pc_d    = branchTarget;
            taken_d = 1'b1;
`endif
          end
        end
        OP_RETURN: begin
          if (depth_q != '0) begin
            pc_d    = stack_q[sp_prev];
            sp_d    = sp_prev;
            depth_d = depth_q - DW'(1);
            taken_d = 1'b1;
          end else begin
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      pc_q    <= RST_PC;
      taken_q <= 1'b0;
      depth_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      depth_q <= depth_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents need no reset; depth/pointer reset makes them unreachable.
  always_ff @(posedge clock) begin
    if (resetN && push_en) begin
      stack_q[sp_q] <= pc_inc;
    end
  end

  assign pc             = pc_q;
  assign branchTaken    = taken_q;
  assign stackDepth     = depth_q;
  assign stackOverflow  = ovf_q;
  assign stackUnderflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model queues expected state per step, compared after the edge.
module tb_pc_sequencer;

  localparam int PCW   = 8;
  localparam int DEPTH = 4;

  logic           clock = 1'b0;
  logic           resetN;
  logic [3:0]     ALUOP;
  logic           zero, negative, stall;
  logic [1:0]     branchCond;
  logic [PCW-1:0] branchTarget;
  logic [PCW-1:0] pc;
  logic           branchTaken;
  logic [2:0]     stackDepth;
  logic           stackOverflow, stackUnderflow;

  pc_sequencer #(.PC_WIDTH(PCW), .STACK_DEPTH(DEPTH), .RESET_VECTOR(0)) dut (
    .clock(clock), .resetN(resetN), .ALUOP(ALUOP), .zero(zero), .negative(negative),
    .branchCond(branchCond), .branchTarget(branchTarget), .stall(stall), .pc(pc),
    .branchTaken(branchTaken), .stackDepth(stackDepth), .stackOverflow(stackOverflow),
    .stackUnderflow(stackUnderflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [PCW-1:0] pc;
    logic           bt;
    int             depth;
    logic           ovf;
    logic           unf;
  } exp_t;

  exp_t           exp_q[$];
  logic [PCW-1:0] m_stack[$];
  logic [PCW-1:0] m_pc;
  logic           m_bt, m_ovf, m_unf;
  int             n_checks = 0;
  int             n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic cond_of(input logic [1:0] c, input logic z, input logic n);
    case (c)
      2'b00:   return z;
      2'b01:   return n;
      2'b10:   return !z;
      default: return !n;
    endcase
  endfunction

  task automatic model(input logic rst_n, input logic st, input logic [3:0] op,
                       input logic [PCW-1:0] tgt, input logic [1:0] c, input logic z, input logic n);
    logic [PCW-1:0] nxt;
    nxt = m_pc + 8'd1;
    if (!rst_n) begin
      m_pc = '0; m_bt = 0; m_ovf = 0; m_unf = 0;
      m_stack.delete();
      return;
    end
    m_bt = 0;
    if (st) return;
    case (op)
      4'b1001: begin m_pc = tgt; m_bt = 1; end
      4'b1010: if (cond_of(c, z, n)) begin m_pc = tgt; m_bt = 1; end else m_pc = nxt;
      4'b1011: begin
        if (m_stack.size() < DEPTH) begin
          m_stack.push_back(nxt); m_pc = tgt; m_bt = 1;
        end else begin
          m_ovf = 1;
`ifdef PC_STACK_WRAP_EN
          void'(m_stack.pop_front());
          m_stack.push_back(nxt); m_pc = tgt; m_bt = 1;
`else
          m_pc = nxt;
`endif
        end
      end
      4'b1100: begin
        if (m_stack.size() > 0) begin m_pc = m_stack.pop_back(); m_bt = 1; end
        else begin m_unf = 1; m_pc = nxt; end
      end
      default: m_pc = nxt;
    endcase
  endtask

  task automatic step(input logic rst_n, input logic st, input logic [3:0] op,
                      input logic [PCW-1:0] tgt, input logic [1:0] c, input logic z, input logic n);
    exp_t e;
    @(negedge clock);
    resetN = rst_n; stall = st; ALUOP = op; branchTarget = tgt;
    branchCond = c; zero = z; negative = n;
    model(rst_n, st, op, tgt, c, z, n);
    e.pc = m_pc; e.bt = m_bt; e.depth = m_stack.size(); e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    check_eq("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("step rst_n=%0b stall=%0b op=%h tgt=%h -> pc=%h bt=%0b depth=%0d ovf=%0b unf=%0b",
               rst_n, st, op, tgt, pc, branchTaken, stackDepth, stackOverflow, stackUnderflow);
      check_eq("pc", 32'(pc), 32'(e.pc));
      check_eq("branchTaken", 32'(branchTaken), 32'(e.bt));
      check_eq("stackDepth", 32'(stackDepth), 32'(e.depth));
      check_eq("stackOverflow", 32'(stackOverflow), 32'(e.ovf));
      check_eq("stackUnderflow", 32'(stackUnderflow), 32'(e.unf));
    end
  endtask

  // Shorthand for an unstalled, out-of-reset instruction.
  task automatic op_run(input logic [3:0] op, input logic [PCW-1:0] tgt);
    step(1, 0, op, tgt, 2'b00, 0, 0);
  endtask

  initial begin
    resetN = 0; stall = 0; ALUOP = 0; branchTarget = 0; branchCond = 0; zero = 0; negative = 0;
    m_pc = '0; m_bt = 0; m_ovf = 0; m_unf = 0;

    // Reset, sequential NOPs, PC wrap with ADD.
    step(0, 0, 4'h0, 8'h00, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) op_run(4'h0, 8'h00);
    op_run(4'b1001, 8'hFF);
    op_run(4'b0001, 8'h00);
    check_eq("pc_wrap_const", 32'(pc), 32'h00);

    // Conditional branches.
    step(1, 0, 4'b1010, 8'h40, 2'b00, 1, 0);
    check_eq("brc_z_taken_const", 32'(pc), 32'h40);
    step(1, 0, 4'b1010, 8'h70, 2'b00, 0, 0);
    step(1, 0, 4'b1010, 8'h60, 2'b11, 0, 0);
    step(1, 0, 4'b1010, 8'h20, 2'b01, 0, 1);
    step(1, 0, 4'b1010, 8'h30, 2'b10, 1, 0);

    // Nested call and return.
    op_run(4'b1001, 8'h10);
    op_run(4'b1011, 8'h80);
    op_run(4'h0, 8'h00);
    op_run(4'b1011, 8'hA0);
    op_run(4'b1100, 8'h00);
    check_eq("ret1_const", 32'(pc), 32'h82);
    op_run(4'b1100, 8'h00);
    check_eq("ret2_const", 32'(pc), 32'h11);

    // Fill the stack, then overflow, then drain past empty.
    op_run(4'b1001, 8'h2C);
    op_run(4'b1011, 8'h2D);
    op_run(4'b1011, 8'h2E);
    op_run(4'b1011, 8'h2F);
    op_run(4'b1011, 8'h30);
    op_run(4'b1011, 8'h90);
`ifndef PC_STACK_WRAP_EN
    check_eq("ovf_pc_const", 32'(pc), 32'h31);
`endif
    check_eq("ovf_depth_const", 32'(stackDepth), 32'd4);
    for (int i = 0; i < 5; i++) op_run(4'b1100, 8'h00);

    // RETURN straight after reset underflows; flag is sticky until reset.
    step(0, 0, 4'h0, 8'h00, 2'b00, 0, 0);
    op_run(4'b1100, 8'h00);
    check_eq("unf_pc_const", 32'(pc), 32'h01);
    op_run(4'h0, 8'h00);
    op_run(4'b1001, 8'h12);
    step(0, 0, 4'h0, 8'h00, 2'b00, 0, 0);

    // Stall holds a BR; reset dominates stall.
    op_run(4'b1011, 8'h44);
    for (int i = 0; i < 3; i++) step(1, 1, 4'b1001, 8'h55, 2'b00, 0, 0);
    op_run(4'b1001, 8'h55);
    step(1, 1, 4'b1100, 8'h00, 2'b00, 0, 0);
    step(0, 1, 4'b1001, 8'h55, 2'b00, 0, 0);
    check_eq("rst_stall_const", 32'(pc), 32'h00);

    // Random mix weighted towards control-flow opcodes.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(9, 12)) : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0), op,
           8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
